// File: rtl/auth_pkg.sv
// Shared constants and default account/PIN tables for the ATM authenticator.
// The optional lockout feature is selected with the AUTH_LOCKOUT_EN macro.
package auth_pkg;

    localparam int ACC_W = 12;
    localparam int PIN_W = 4;
    localparam int IDX_W = 4;
    localparam int N_ACC = 10;

    localparam int MAX_FAIL = 3;

    typedef enum logic {
        FIND         = 1'b0,
        AUTHENTICATE = 1'b1
    } mode_e;

    localparam logic [IDX_W-1:0] NO_INDEX = 4'hF;

    // Entry i sits at bits [i*ACC_W +: ACC_W]; entry 0 is the least significant
    localparam logic [N_ACC*ACC_W-1:0] DEFAULT_ACC_TABLE = {
        12'h109, 12'h108, 12'h107, 12'h106, 12'h105,
        12'h104, 12'h103, 12'h102, 12'h101, 12'h100
    };

    localparam logic [N_ACC*PIN_W-1:0] DEFAULT_PIN_TABLE = {
        4'hA, 4'h9, 4'h8, 4'h7, 4'h6,
        4'h5, 4'h4, 4'h3, 4'h2, 4'h1
    };

endpackage

// File: rtl/auth_lookup.sv
// Combinational account-table lookup: lowest matching index wins,
// NO_INDEX is returned when no entry matches.
module auth_lookup
    import auth_pkg::*;
#(
    parameter int                       N_ACC     = auth_pkg::N_ACC,
    parameter int                       ACC_W     = auth_pkg::ACC_W,
    parameter int                       IDX_W     = auth_pkg::IDX_W,
    parameter logic [N_ACC*ACC_W-1:0]   ACC_TABLE = auth_pkg::DEFAULT_ACC_TABLE
) (
    input  logic [ACC_W-1:0] acc_number,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    // Scanning from the top down lets the lowest duplicate overwrite the rest
    always_comb begin
        hit = 1'b0;
        idx = NO_INDEX;
        for (int i = N_ACC - 1; i >= 0; i--) begin
            if (ACC_TABLE[i*ACC_W +: ACC_W] == acc_number) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/authenticator.sv
// Account lookup and PIN authentication with a single sticky session.
// Define AUTH_LOCKOUT_EN to add per-account fail counters and lockout.
module authenticator
    import auth_pkg::*;
#(
    parameter int                       N_ACC     = auth_pkg::N_ACC,
    parameter int                       ACC_W     = auth_pkg::ACC_W,
    parameter int                       PIN_W     = auth_pkg::PIN_W,
    parameter int                       IDX_W     = auth_pkg::IDX_W,
    parameter logic [N_ACC*ACC_W-1:0]   ACC_TABLE = auth_pkg::DEFAULT_ACC_TABLE,
    parameter logic [N_ACC*PIN_W-1:0]   PIN_TABLE = auth_pkg::DEFAULT_PIN_TABLE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ACC_W-1:0] acc_number,
    input  logic [PIN_W-1:0] pin,
    input  logic             mode,
    input  logic             de_auth,
    output logic             valid,
    output logic [IDX_W-1:0] acc_index
);

    logic             hit;
    logic [IDX_W-1:0] idx;
    logic             sess_act;
    logic [IDX_W-1:0] sess_idx;
    logic             pin_ok;
    logic             sess_match;
    logic             locked;

    auth_lookup #(
        .N_ACC     (N_ACC),
        .ACC_W     (ACC_W),
        .IDX_W     (IDX_W),
        .ACC_TABLE (ACC_TABLE)
    ) u_lookup (
        .acc_number (acc_number),
        .hit        (hit),
        .idx        (idx)
    );

    // Table reads go through a loop so an out-of-range index reads as zero
    function automatic logic [PIN_W-1:0] pin_at(input logic [IDX_W-1:0] k);
        pin_at = '0;
        for (int i = 0; i < N_ACC; i++)
            if (IDX_W'(i) == k) pin_at = PIN_TABLE[i*PIN_W +: PIN_W];
    endfunction

    function automatic logic [ACC_W-1:0] acc_at(input logic [IDX_W-1:0] k);
        acc_at = '0;
        for (int i = 0; i < N_ACC; i++)
            if (IDX_W'(i) == k) acc_at = ACC_TABLE[i*ACC_W +: ACC_W];
    endfunction

    assign pin_ok     = hit && (pin == pin_at(idx));
    assign sess_match = sess_act && (acc_number == acc_at(sess_idx));

`ifdef AUTH_LOCKOUT_EN
    logic [1:0] fail_cnt [N_ACC];
    logic [1:0] cnt_at_idx;

    always_comb begin
        cnt_at_idx = 2'd0;
        for (int i = 0; i < N_ACC; i++)
            if (IDX_W'(i) == idx) cnt_at_idx = fail_cnt[i];
    end

    assign locked = hit && (int'(cnt_at_idx) >= MAX_FAIL);
`else
    assign locked = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid     <= 1'b0;
            acc_index <= NO_INDEX;
            sess_act  <= 1'b0;
            sess_idx  <= NO_INDEX;
`ifdef AUTH_LOCKOUT_EN
            for (int i = 0; i < N_ACC; i++) fail_cnt[i] <= 2'd0;
`endif
        end else if (mode == FIND) begin
            valid     <= hit;
            acc_index <= hit ? idx : NO_INDEX;
            if (de_auth) begin
                sess_act <= 1'b0;
                sess_idx <= NO_INDEX;
            end
        end else if (de_auth) begin
            valid     <= 1'b0;
            acc_index <= NO_INDEX;
            sess_act  <= 1'b0;
            sess_idx  <= NO_INDEX;
        end else if (sess_match) begin
            // Sticky session: PIN is not re-checked for the session's account
            valid     <= 1'b1;
            acc_index <= sess_idx;
        end else if (pin_ok && !locked) begin
            valid     <= 1'b1;
            acc_index <= idx;
            sess_act  <= 1'b1;
            sess_idx  <= idx;
`ifdef AUTH_LOCKOUT_EN
            for (int i = 0; i < N_ACC; i++)
                if (IDX_W'(i) == idx) fail_cnt[i] <= 2'd0;
`endif
        end else begin
            valid     <= 1'b0;
            acc_index <= NO_INDEX;
            if (sess_act) begin
                sess_act <= 1'b0;
                sess_idx <= NO_INDEX;
            end
`ifdef AUTH_LOCKOUT_EN
            if (hit && !pin_ok && cnt_at_idx != 2'd3) begin
                for (int i = 0; i < N_ACC; i++)
                    if (IDX_W'(i) == idx) fail_cnt[i] <= cnt_at_idx + 2'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_authenticator.sv
// Scoreboard bench for authenticator: directed plan steps plus random traffic
// against a table-driven reference model (lockout checks need AUTH_LOCKOUT_EN).
module tb_authenticator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] acc_number = 12'h000;
    logic [3:0]  pin = 4'h0;
    logic        mode = 1'b0;
    logic        de_auth = 1'b0;
    logic        valid;
    logic [3:0]  acc_index;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       v;
        logic [3:0] i;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    // Reference model state
    bit m_sess_act = 1'b0;
    int m_sess_idx = 15;
    int m_fail[10];

    authenticator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .acc_number (acc_number),
        .pin        (pin),
        .mode       (mode),
        .de_auth    (de_auth),
        .valid      (valid),
        .acc_index  (acc_index)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are sampled 1 time unit after each rising edge
    always @(posedge clk) begin
        #1;
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            n_tests++;
            if (valid !== mon_e.v || acc_index !== mon_e.i) begin
                n_fail++;
                $display("FAIL %s: got valid=%0b acc_index=%h, expected valid=%0b acc_index=%h",
                         mon_e.name, valid, acc_index, mon_e.v, mon_e.i);
            end
        end
    end

    function automatic int table_find(input logic [11:0] a);
        for (int i = 0; i < 10; i++)
            if (a == 12'h100 + 12'(i)) return i;
        return -1;
    endfunction

    function automatic bit is_locked(input int k);
`ifdef AUTH_LOCKOUT_EN
        return m_fail[k] >= 3;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step(input logic r, input logic [11:0] a, input logic [3:0] p,
                              input logic m, input logic d,
                              output logic ev, output logic [3:0] ei);
        int k;
        k  = table_find(a);
        ev = 1'b0;
        ei = 4'hF;
        if (!r) begin
            m_sess_act = 1'b0;
            m_sess_idx = 15;
            for (int i = 0; i < 10; i++) m_fail[i] = 0;
        end else if (m == 1'b0) begin
            if (k >= 0) begin ev = 1'b1; ei = 4'(k); end
            if (d) begin m_sess_act = 1'b0; m_sess_idx = 15; end
        end else if (d) begin
            m_sess_act = 1'b0;
            m_sess_idx = 15;
        end else if (m_sess_act && k == m_sess_idx) begin
            ev = 1'b1;
            ei = 4'(m_sess_idx);
        end else if (k >= 0 && int'(p) == k + 1 && !is_locked(k)) begin
            ev = 1'b1;
            ei = 4'(k);
            m_sess_act = 1'b1;
            m_sess_idx = k;
            m_fail[k] = 0;
        end else begin
            m_sess_act = 1'b0;
            m_sess_idx = 15;
            if (k >= 0 && int'(p) != k + 1 && m_fail[k] < 3) m_fail[k]++;
        end
    endtask

    // Directed step: expectation is a hand-written constant; the model is kept in step
    task automatic step_exp(input string name, input logic r, input logic [11:0] a,
                            input logic [3:0] p, input logic m, input logic d,
                            input logic ev, input logic [3:0] ei);
        logic       mv;
        logic [3:0] mi;
        exp_t       e;
        @(negedge clk);
        rst_n = r; acc_number = a; pin = p; mode = m; de_auth = d;
        model_step(r, a, p, m, d, mv, mi);
        e.v = ev; e.i = ei; e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic step_rand();
        logic       r, m, d, mv;
        logic [11:0] a;
        logic [3:0]  p, mi;
        int          k;
        exp_t        e;
        r = ($urandom_range(0, 99) != 0);
        a = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'h0FE + 12'($urandom_range(0, 13));
        k = table_find(a);
        p = ($urandom_range(0, 1) == 1 && k >= 0) ? 4'(k + 1) : 4'($urandom);
        m = 1'($urandom);
        d = ($urandom_range(0, 15) == 0);
        @(negedge clk);
        rst_n = r; acc_number = a; pin = p; mode = m; de_auth = d;
        model_step(r, a, p, m, d, mv, mi);
        e.v = mv; e.i = mi; e.name = "random";
        sb_q.push_back(e);
    endtask

    initial begin
        for (int i = 0; i < 10; i++) m_fail[i] = 0;

        step_exp("reset_0", 0, 12'h104, 4'h0, 0, 0, 1'b0, 4'hF);
        step_exp("reset_1", 0, 12'h104, 4'h0, 0, 0, 1'b0, 4'hF);
        step_exp("find_104", 1, 12'h104, 4'h0, 0, 0, 1'b1, 4'h4);
        step_exp("find_miss_200", 1, 12'h200, 4'h7, 0, 0, 1'b0, 4'hF);
        step_exp("find_109", 1, 12'h109, 4'h0, 0, 0, 1'b1, 4'h9);
        step_exp("find_000", 1, 12'h000, 4'h1, 0, 0, 1'b0, 4'hF);
        step_exp("find_fff", 1, 12'hFFF, 4'h1, 0, 0, 1'b0, 4'hF);
        step_exp("auth_103", 1, 12'h103, 4'h4, 1, 0, 1'b1, 4'h3);
        step_exp("sticky_103", 1, 12'h103, 4'h0, 1, 0, 1'b1, 4'h3);
        step_exp("wrong_pin_105", 1, 12'h105, 4'h1, 1, 0, 1'b0, 4'hF);
        step_exp("reauth_103", 1, 12'h103, 4'h4, 1, 0, 1'b1, 4'h3);
        step_exp("deauth_103", 1, 12'h103, 4'h4, 1, 1, 1'b0, 4'hF);
        step_exp("post_deauth", 1, 12'h103, 4'h0, 1, 0, 1'b0, 4'hF);
        step_exp("auth_again", 1, 12'h103, 4'h4, 1, 0, 1'b1, 4'h3);
        step_exp("auth_100", 1, 12'h100, 4'h1, 1, 0, 1'b1, 4'h0);
        step_exp("handoff_101", 1, 12'h101, 4'h0, 1, 0, 1'b0, 4'hF);
        step_exp("back_to_100", 1, 12'h100, 4'h0, 1, 0, 1'b0, 4'hF);
        step_exp("auth_000", 1, 12'h000, 4'h0, 1, 0, 1'b0, 4'hF);
        step_exp("auth_107", 1, 12'h107, 4'h8, 1, 0, 1'b1, 4'h7);
        step_exp("find_mid", 1, 12'h101, 4'h0, 0, 0, 1'b1, 4'h1);
        step_exp("resume_107", 1, 12'h107, 4'h0, 1, 0, 1'b1, 4'h7);
        step_exp("find_deauth", 1, 12'h107, 4'h0, 0, 1, 1'b1, 4'h7);
        step_exp("after_find_deauth", 1, 12'h107, 4'h0, 1, 0, 1'b0, 4'hF);
`ifdef AUTH_LOCKOUT_EN
        step_exp("lock_reset", 0, 12'h000, 4'h0, 0, 0, 1'b0, 4'hF);
        step_exp("lock_try_1", 1, 12'h102, 4'h0, 1, 0, 1'b0, 4'hF);
        step_exp("lock_try_2", 1, 12'h102, 4'h0, 1, 0, 1'b0, 4'hF);
        step_exp("lock_try_3", 1, 12'h102, 4'h0, 1, 0, 1'b0, 4'hF);
        step_exp("locked_good_pin", 1, 12'h102, 4'h3, 1, 0, 1'b0, 4'hF);
        step_exp("locked_find", 1, 12'h102, 4'h0, 0, 0, 1'b1, 4'h2);
        step_exp("unlock_reset", 0, 12'h102, 4'h3, 1, 0, 1'b0, 4'hF);
        step_exp("unlocked_auth", 1, 12'h102, 4'h3, 1, 0, 1'b1, 4'h2);
`endif

        repeat (2000) step_rand();

        // Let the monitor drain the remaining expectations, bounded
        for (int c = 0; c < 20 && sb_q.size() != 0; c++) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
